// File: rtl/agh_st2mm_writer.sv
// agh_st2mm_writer: Avalon-ST (16-bit samples) to Avalon-MM (32-bit words) write engine.
// Sample pairs are packed little-endian by half-word and written one word at a time.
// A transfer ends on word count, endofpacket, abort or (optionally) a write error.
// Optional feature macro: AGH_ST2MM_RESP_CHECK_EN adds a RESP state that waits for
// and checks each write response; without it a write completes on waitrequest = 0.
module agh_st2mm_writer #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [LEN_W-1:0]  cfg_len_words,
  output logic              sts_busy,
  output logic              sts_done,
  output logic              sts_error,
  output logic [LEN_W-1:0]  sts_words,
  input  logic [15:0]       avalon_streaming_sink_data,
  input  logic              avalon_streaming_sink_valid,
  input  logic              avalon_streaming_sink_startofpacket,
  input  logic              avalon_streaming_sink_endofpacket,
  output logic              avalon_streaming_sink_ready,
  output logic [ADDR_W-1:0] avalon_mm_master_address,
  output logic              avalon_mm_master_write,
  output logic [31:0]       avalon_mm_master_writedata,
  output logic [3:0]        avalon_mm_master_byteenable,
  input  logic              avalon_mm_master_waitrequest,
  input  logic [1:0]        avalon_mm_master_response,
  input  logic              avalon_mm_master_writeresponsevalid
);

`ifdef AGH_ST2MM_RESP_CHECK_EN
  typedef enum logic [2:0] {ST_IDLE, ST_FILL, ST_WRITE, ST_RESP, ST_DONE} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_FILL, ST_WRITE, ST_DONE} state_t;
`endif

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic [31:0]         data_reg;
  logic [3:0]          be_reg;
  logic [LEN_W-1:0]    len_reg;
  logic [LEN_W-1:0]    words_reg;
  logic                half_reg;   // lower half-word of the current word is filled
  logic                eop_reg;    // current word carries the packet's last sample
  logic                abort_reg;  // abort seen while a write was outstanding
  logic                error_reg;

  logic                sample_accept;
  logic [LEN_W-1:0]    words_inc;
  logic                len_hit;
  logic                stop_xfer;

  // Start-of-packet carries no meaning here; the low address bits are forced to zero.
  // Without response checking the response inputs are not used either.
  logic unused_ok;
`ifdef AGH_ST2MM_RESP_CHECK_EN
  assign unused_ok = &{1'b0, avalon_streaming_sink_startofpacket, cfg_base_addr[1:0]};
`else
  assign unused_ok = &{1'b0, avalon_streaming_sink_startofpacket, cfg_base_addr[1:0],
                       avalon_mm_master_response, avalon_mm_master_writeresponsevalid};
`endif

  assign avalon_streaming_sink_ready = (state_reg == ST_FILL) && !cfg_abort;
  assign sample_accept = avalon_streaming_sink_valid && avalon_streaming_sink_ready;

  // In WRITE the count has not been bumped yet, so compare against the post-accept value.
  assign words_inc = words_reg + LEN_W'(1);
  assign len_hit   = (state_reg == ST_WRITE) ? (words_inc == len_reg) : (words_reg == len_reg);
  assign stop_xfer = len_hit || eop_reg || abort_reg || cfg_abort;

  assign sts_busy  = (state_reg != ST_IDLE);
  assign sts_done  = (state_reg == ST_DONE);
  assign sts_error = error_reg;
  assign sts_words = words_reg;

  assign avalon_mm_master_write      = (state_reg == ST_WRITE);
  assign avalon_mm_master_address    = addr_reg;
  assign avalon_mm_master_writedata  = data_reg;
  assign avalon_mm_master_byteenable = be_reg;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (cfg_start) state_next = (cfg_len_words == '0) ? ST_DONE : ST_FILL;
      end
      ST_FILL: begin
        if (cfg_abort) state_next = ST_DONE;
        else if (sample_accept && (half_reg || avalon_streaming_sink_endofpacket))
          state_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (!avalon_mm_master_waitrequest) begin
`ifdef AGH_ST2MM_RESP_CHECK_EN
          state_next = ST_RESP;
`else
          state_next = stop_xfer ? ST_DONE : ST_FILL;
`endif
        end
      end
`ifdef AGH_ST2MM_RESP_CHECK_EN
      ST_RESP: begin
        if (avalon_mm_master_writeresponsevalid) begin
          if (avalon_mm_master_response != 2'b00) state_next = ST_DONE;
          else state_next = stop_xfer ? ST_DONE : ST_FILL;
        end
      end
`endif
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: config latch, half-word packing, address/count and status updates
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_reg  <= '0;
      data_reg  <= '0;
      be_reg    <= '0;
      len_reg   <= '0;
      words_reg <= '0;
      half_reg  <= 1'b0;
      eop_reg   <= 1'b0;
      abort_reg <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (cfg_start) begin
            addr_reg  <= {cfg_base_addr[ADDR_W-1:2], 2'b00};
            len_reg   <= cfg_len_words;
            words_reg <= '0;
            error_reg <= 1'b0;
            half_reg  <= 1'b0;
            eop_reg   <= 1'b0;
            abort_reg <= 1'b0;
          end
        end
        ST_FILL: begin
          if (sample_accept) begin
            if (!half_reg) begin
              data_reg[15:0] <= avalon_streaming_sink_data;
              if (avalon_streaming_sink_endofpacket) begin
                data_reg[31:16] <= '0;
                be_reg          <= 4'b0011;
                eop_reg         <= 1'b1;
              end else begin
                half_reg <= 1'b1;
              end
            end else begin
              data_reg[31:16] <= avalon_streaming_sink_data;
              be_reg          <= 4'b1111;
              half_reg        <= 1'b0;
              eop_reg         <= avalon_streaming_sink_endofpacket;
            end
          end
        end
        ST_WRITE: begin
          if (cfg_abort) abort_reg <= 1'b1;
          if (!avalon_mm_master_waitrequest) begin
            words_reg <= words_inc;
            addr_reg  <= addr_reg + ADDR_W'(4);
          end
        end
`ifdef AGH_ST2MM_RESP_CHECK_EN
        ST_RESP: begin
          if (cfg_abort) abort_reg <= 1'b1;
          if (avalon_mm_master_writeresponsevalid && (avalon_mm_master_response != 2'b00))
            error_reg <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_agh_st2mm_writer.sv
// tb_agh_st2mm_writer: scoreboard bench. The stimulus side computes expected writes from the
// pending sample stream and pushes them into a queue; a forked monitor pops and compares on
// every accepted Avalon-MM write.
module tb_agh_st2mm_writer;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_start, cfg_abort;
  logic [ADDR_W-1:0] cfg_base_addr;
  logic [LEN_W-1:0]  cfg_len_words;
  logic              sts_busy, sts_done, sts_error;
  logic [LEN_W-1:0]  sts_words;
  logic [15:0]       st_data;
  logic              st_valid, st_sop, st_eop, st_ready;
  logic [ADDR_W-1:0] mm_addr;
  logic              mm_write;
  logic [31:0]       mm_wdata;
  logic [3:0]        mm_be;
  logic              mm_waitreq;
  logic [1:0]        mm_resp;
  logic              mm_rvalid;

  agh_st2mm_writer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_base_addr(cfg_base_addr), .cfg_len_words(cfg_len_words),
    .sts_busy(sts_busy), .sts_done(sts_done), .sts_error(sts_error), .sts_words(sts_words),
    .avalon_streaming_sink_data(st_data), .avalon_streaming_sink_valid(st_valid),
    .avalon_streaming_sink_startofpacket(st_sop), .avalon_streaming_sink_endofpacket(st_eop),
    .avalon_streaming_sink_ready(st_ready),
    .avalon_mm_master_address(mm_addr), .avalon_mm_master_write(mm_write),
    .avalon_mm_master_writedata(mm_wdata), .avalon_mm_master_byteenable(mm_be),
    .avalon_mm_master_waitrequest(mm_waitreq), .avalon_mm_master_response(mm_resp),
    .avalon_mm_master_writeresponsevalid(mm_rvalid)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed { logic [15:0] data; logic eop; } samp_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] data; logic [3:0] be; } wr_t;

  samp_t src_q[$];
  wr_t   exp_q[$];
  int    vecs = 0, errs = 0;
  int    done_cnt = 0, consumed = 0, acc_idx = 0, err_at = -1, stall_left = 0;
  bit    rand_valid = 0, rand_wait = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    vecs++;
    if (act !== exp_v) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Scoreboard monitor: compares every accepted write, checks stall stability and ready.
  task automatic monitor();
    logic prev_stall = 1'b0;
    logic [31:0] pa = '0, pd = '0;
    logic [3:0]  pb = '0;
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_write", 64'(mm_write), 64'(1));
          chk("stall_addr", 64'(mm_addr), 64'(pa));
          chk("stall_data", 64'(mm_wdata), 64'(pd));
          chk("stall_be", 64'(mm_be), 64'(pb));
        end
        if (mm_write) chk("ready_in_write", 64'(st_ready), 64'(0));
        if (mm_write && !mm_waitreq) begin
          if (exp_q.size() == 0) begin
            vecs++; errs++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                     mm_addr, mm_wdata);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 64'(mm_addr), 64'(e.addr));
            chk("wr_data", 64'(mm_wdata), 64'(e.data));
            chk("wr_be", 64'(mm_be), 64'(e.be));
            $display("write addr=0x%08h data=0x%08h be=%b", mm_addr, mm_wdata, mm_be);
          end
        end
        if (sts_done) done_cnt++;
        prev_stall = mm_write && mm_waitreq;
        pa = mm_addr; pd = mm_wdata; pb = mm_be;
      end
    end
  endtask

  // One clock: sample handshakes at negedge, then drive stream and slave 1 ns after posedge.
  task automatic step();
    bit took, acc;
    samp_t dummy;
    @(negedge clk);
    took = st_valid && st_ready;
    acc  = mm_write && !mm_waitreq;
    @(posedge clk); #1;
    if (took && src_q.size() > 0) begin dummy = src_q.pop_front(); consumed++; end
    mm_rvalid = acc;
    mm_resp   = (acc && acc_idx == err_at) ? 2'b10 : 2'b00;
    if (acc) acc_idx++;
    if (stall_left > 0) begin
      mm_waitreq = 1'b1;
      if (mm_write) stall_left--;
    end else begin
      mm_waitreq = rand_wait ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
    if (src_q.size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0)) begin
      st_valid = 1'b1; st_data = src_q[0].data; st_eop = src_q[0].eop;
    end else begin
      st_valid = 1'b0; st_data = 16'($urandom); st_eop = 1'b0;
    end
  endtask

  task automatic push_samp(input logic [15:0] d, input logic e);
    samp_t s;
    s.data = d; s.eop = e;
    src_q.push_back(s);
  endtask

  task automatic push_rand(input int n, input bit with_eop);
    for (int i = 0; i < n; i++) push_samp(16'($urandom), with_eop && (i == n - 1));
  endtask

  // Reference model: walk the pending stream pair by pair and list the words to be written.
  task automatic build_exp(input logic [31:0] base, input int len, input int limit,
                           output int nw, output int ns);
    int i;
    bit fin;
    wr_t w;
    logic [31:0] base_al;
    base_al = base & 32'hFFFF_FFFC;
    nw = 0; ns = 0; i = 0; fin = 0;
    while (!fin && nw < len && nw < limit && i < src_q.size()) begin
      w.addr = base_al + 32'(4 * nw);
      if (src_q[i].eop) begin
        w.data = {16'h0000, src_q[i].data}; w.be = 4'b0011;
        ns = i + 1; fin = 1;
      end else if (i + 1 < src_q.size()) begin
        w.data = {src_q[i+1].data, src_q[i].data}; w.be = 4'b1111;
        ns = i + 2; fin = src_q[i+1].eop;
      end else begin
        break;
      end
      exp_q.push_back(w);
      nw++;
      i += 2;
    end
  endtask

  // mode: 0 plain, 1 start while busy, 2 abort in stalled WRITE, 3 abort in FILL after one sample
  task automatic run_xfer(input string tag, input logic [31:0] base, input int len, input int mode);
    int nw, ns, limit, exp_ns, d0;
    bit exp_err, fired;
    limit = 1 << 30;
    if (mode == 2) limit = 1;
    if (mode == 3) limit = 0;
    exp_err = 0;
`ifdef AGH_ST2MM_RESP_CHECK_EN
    if (err_at >= 0) limit = err_at + 1;
`endif
    build_exp(base, len, limit, nw, ns);
`ifdef AGH_ST2MM_RESP_CHECK_EN
    if (err_at >= 0 && nw == err_at + 1) exp_err = 1;
`endif
    exp_ns = (mode == 3) ? 1 : ns;
    consumed = 0; acc_idx = 0; d0 = done_cnt;
    cfg_base_addr = base; cfg_len_words = LEN_W'(len); cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    fired = 0;
    for (int cyc = 0; cyc < 400 && done_cnt == d0; cyc++) begin
      if (mode == 1 && cyc == 3) begin
        cfg_start = 1'b1; cfg_base_addr = $urandom; cfg_len_words = LEN_W'($urandom_range(1, 9));
      end
      if (mode == 2 && !fired && mm_write && mm_waitreq) begin cfg_abort = 1'b1; fired = 1; end
      if (mode == 3 && !fired && consumed == 1) begin cfg_abort = 1'b1; fired = 1; end
      step();
      cfg_start = 1'b0; cfg_abort = 1'b0;
    end
    chk({tag, "_done_timeout"}, 64'(done_cnt != d0), 64'(1));
    chk({tag, "_words"}, 64'(sts_words), 64'(nw));
    chk({tag, "_error"}, 64'(sts_error), 64'(exp_err));
    chk({tag, "_busy"}, 64'(sts_busy), 64'(0));
    chk({tag, "_samples"}, 64'(consumed), 64'(exp_ns));
    chk({tag, "_pending_writes"}, 64'(exp_q.size()), 64'(0));
    step(); step();
    chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'(1));
    $display("xfer %s base=0x%08h len=%0d words=%0d err=%0d samples=%0d",
             tag, base, len, sts_words, sts_error, consumed);
    exp_q.delete();
  endtask

  initial begin
    int d0, len, n;
    bit we;
    logic [31:0] base;
    rst_n = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_base_addr = '0; cfg_len_words = '0;
    st_data = '0; st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
    mm_waitreq = 1'b0; mm_resp = 2'b00; mm_rvalid = 1'b0;
    fork monitor(); join_none
    repeat (3) step();
    chk("rst_addr", 64'(mm_addr), 64'(0));
    chk("rst_write", 64'(mm_write), 64'(0));
    chk("rst_wdata", 64'(mm_wdata), 64'(0));
    chk("rst_be", 64'(mm_be), 64'(0));
    chk("rst_status", 64'({sts_busy, sts_done, sts_error, st_ready}), 64'(0));
    chk("rst_words", 64'(sts_words), 64'(0));
    rst_n = 1'b1;
    step();

    // Full-length transfer
    push_samp(16'h1111, 0); push_samp(16'h2222, 0); push_samp(16'h3333, 0); push_samp(16'h4444, 0);
    run_xfer("full", 32'h0000_1000, 2, 0);
    // Odd EOP
    push_samp(16'h5555, 0); push_samp(16'h6666, 0); push_samp(16'hAAAA, 1);
    run_xfer("odd_eop", 32'h0000_2000, 8, 0);
    // Slave stall of 5 cycles
    push_samp(16'hBEEF, 0); push_samp(16'hCAFE, 0);
    stall_left = 5;
    run_xfer("stall", 32'h0000_3003, 1, 0);
    // Abort in FILL after one sample, then abort during a stalled WRITE
    push_rand(3, 0);
    run_xfer("abort_fill", 32'h0000_4000, 2, 3);
    push_rand(6, 0);
    stall_left = 3;
    run_xfer("abort_write", 32'h0000_5000, 3, 2);
    src_q.delete();
    // Start while busy is ignored
    push_rand(6, 0);
    run_xfer("busy_start", 32'h0000_6000, 3, 1);
    // Length zero: done the next cycle, no sink handshake
    push_rand(2, 0);
    consumed = 0; d0 = done_cnt;
    cfg_len_words = '0; cfg_base_addr = 32'h7000; cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    chk("len0_done_next", 64'(sts_done), 64'(1));
    step(); step();
    chk("len0_done_pulses", 64'(done_cnt - d0), 64'(1));
    chk("len0_samples", 64'(consumed), 64'(0));
    chk("len0_words", 64'(sts_words), 64'(0));
    $display("xfer len0 done=%0d samples=%0d", done_cnt - d0, consumed);
`ifdef AGH_ST2MM_RESP_CHECK_EN
    // Error response on the first of four words, then a clean start clears the flag
    push_rand(8, 0);
    err_at = 0;
    run_xfer("resp_err", 32'h0000_8000, 4, 0);
    err_at = -1;
    run_xfer("err_clear", 32'h0000_9000, 1, 0);
`endif
    // Randomized transfers with stalls and valid gaps; leftovers carry into the next start
    rand_valid = 1; rand_wait = 1;
    for (int it = 0; it < 8; it++) begin
      len  = (it == 0) ? 4 : $urandom_range(1, 5);
      base = (it == 0) ? 32'hFFFF_FFFA : $urandom;
      we   = (it == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      n    = we ? $urandom_range(1, 2 * len + 2) : 2 * len + $urandom_range(0, 2);
      push_rand(n, we);
      run_xfer("rand", base, len, 0);
    end
    rand_valid = 0; rand_wait = 0;
    // Reset in the middle of a stalled write
    src_q.delete();
    push_rand(2, 0);
    stall_left = 20;
    cfg_base_addr = 32'h0000_A000; cfg_len_words = LEN_W'(1); cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int cyc = 0; cyc < 50 && !mm_write; cyc++) step();
    chk("midrst_in_write", 64'(mm_write), 64'(1));
    rst_n = 1'b0;
    step();
    chk("midrst_addr", 64'(mm_addr), 64'(0));
    chk("midrst_wdata", 64'(mm_wdata), 64'(0));
    chk("midrst_be", 64'(mm_be), 64'(0));
    chk("midrst_status", 64'({mm_write, sts_busy, sts_done, sts_error, st_ready}), 64'(0));
    chk("midrst_words", 64'(sts_words), 64'(0));
    $display("reset mid-write write=%0d busy=%0d", mm_write, sts_busy);
    rst_n = 1'b1; stall_left = 0;
    src_q.delete(); exp_q.delete();
    step();
    push_samp(16'h0123, 0); push_samp(16'h4567, 1);
    run_xfer("after_rst", 32'h0000_B000, 4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
